// File: rtl/wb_data_ram_responder_pkg.sv
// rtl/wb_data_ram_responder_pkg.sv - shared widths and FSM encoding for the data-RAM responder
package wb_data_ram_responder_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    RSP_IDLE   = 2'd0,
    RSP_ACCESS = 2'd1,
    RSP_ACK    = 2'd2
  } rsp_state_e;

endpackage

// File: rtl/wb_data_ram_responder_rr_arbiter.sv
// rtl/wb_data_ram_responder_rr_arbiter.sv - combinational round-robin pick starting after the last grant
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    w_cand    = '0;
    // Scan last+1 .. last+N so the previous winner is considered last.
    for (int i = 1; i <= N; i++) begin
      w_cand = IDX_W'((int'(last) + i) % N);
      if (!gnt_valid && req[w_cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/wb_data_ram_responder.sv
// rtl/wb_data_ram_responder.sv - multi-master word RAM responder, one transaction per three cycles
module wb_data_ram_responder
  import wb_data_ram_responder_pkg::*;
#(
  parameter int NUM_CPU = 4,
  parameter int ADDR_W  = 10,
  parameter int IDX_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CPU-1:0]        cyc_i,
  input  logic [NUM_CPU-1:0]        we_i,
  input  logic [NUM_CPU*DATA_W-1:0] adr_i,
  input  logic [NUM_CPU*DATA_W-1:0] dat_i,
  output logic [NUM_CPU-1:0]        ack_o,
  output logic [DATA_W-1:0]         dat_o,
  output logic [IDX_W-1:0]          grant_o,
  output logic                      busy_o
);

  localparam int DEPTH = 2**ADDR_W;

  rsp_state_e        r_state;
  rsp_state_e        w_next_state;
  logic [IDX_W-1:0]  r_last;
  logic [IDX_W-1:0]  r_grant;
  logic [IDX_W-1:0]  w_gnt_idx;
  logic              w_gnt_valid;
  logic              w_start;
  logic              r_we;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DATA_W-1:0] w_adr [NUM_CPU];
  logic [DATA_W-1:0] w_dat [NUM_CPU];

  for (genvar k = 0; k < NUM_CPU; k++) begin : g_unpack
    assign w_adr[k] = adr_i[k*DATA_W +: DATA_W];
    assign w_dat[k] = dat_i[k*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N     (NUM_CPU),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (cyc_i),
    .last      (r_last),
    .gnt_idx   (w_gnt_idx),
    .gnt_valid (w_gnt_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RSP_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    busy_o       = (r_state != RSP_IDLE);
    case (r_state)
      RSP_IDLE: begin
        if (w_gnt_valid) begin
          w_start      = 1'b1;
          w_next_state = RSP_ACCESS;
        end
      end
      RSP_ACCESS: w_next_state = RSP_ACK;
      RSP_ACK:    w_next_state = RSP_IDLE;
      default:    w_next_state = RSP_IDLE;
    endcase
  end

  // The ack decision is taken at the end of ACCESS so ack_o stays a pure register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= IDX_W'(NUM_CPU - 1);
      r_grant <= '0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_wdata <= '0;
      ack_o   <= '0;
      dat_o   <= '0;
    end else begin
      ack_o <= '0;
      if (w_start) begin
        r_grant <= w_gnt_idx;
        r_we    <= we_i[w_gnt_idx];
        r_adr   <= w_adr[w_gnt_idx][ADDR_W-1:0];
        r_wdata <= w_dat[w_gnt_idx];
      end
      if (r_state == RSP_ACCESS && cyc_i[r_grant]) begin
        ack_o[r_grant] <= 1'b1;
        dat_o          <= r_we ? r_wdata : r_mem[r_adr];
      end
      if (r_state == RSP_ACK) r_last <= r_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == RSP_ACCESS && r_we) r_mem[r_adr] <= r_wdata;
  end

  assign grant_o = r_grant;

endmodule

// File: tb/tb_wb_data_ram_responder.sv
// tb/tb_wb_data_ram_responder.sv - randomized self-checking bench with a behavioural memory/arbiter model
module tb_wb_data_ram_responder;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    cyc_i;
  logic [N-1:0]    we_i;
  logic [N*32-1:0] adr_i;
  logic [N*32-1:0] dat_i;
  logic [N-1:0]    ack_o;
  logic [31:0]     dat_o;
  logic [IW-1:0]   grant_o;
  logic            busy_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem_m [0:(1<<AW)-1];
  int          wr_list[$];
  int          last_m;

  wb_data_ram_responder #(.NUM_CPU(N), .ADDR_W(AW), .IDX_W(IW)) dut (
    .clk     (clk),
    .rst     (rst),
    .cyc_i   (cyc_i),
    .we_i    (we_i),
    .adr_i   (adr_i),
    .dat_i   (dat_i),
    .ack_o   (ack_o),
    .dat_o   (dat_o),
    .grant_o (grant_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  task automatic single(input int m, input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input string tag);
    int          n;
    logic [31:0] exp;
    logic [3:0]  exp_ack;
    exp     = we ? dat : mem_m[adr[AW-1:0]];
    exp_ack = 4'(1 << m);
    @(negedge clk);
    cyc_i[m] = 1'b1;
    we_i[m]  = we;
    adr_i[m*32 +: 32] = adr;
    dat_i[m*32 +: 32] = dat;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        we_i[m] = ~we;
        dat_i[m*32 +: 32] = $urandom;
        adr_i[m*32 +: 32] = $urandom;
      end
      if (ack_o[m]) break;
    end
    n_checks++;
    if (n !== 2) begin n_fail++; $display("FAIL %s latency: got %0d cycles, want 2", tag, n); end
    n_checks++;
    if (ack_o !== exp_ack) begin n_fail++; $display("FAIL %s ack_vec: got %b, want %b", tag, ack_o, exp_ack); end
    n_checks++;
    if (dat_o !== exp) begin n_fail++; $display("FAIL %s data: got %h, want %h", tag, dat_o, exp); end
    cyc_i[m] = 1'b0;
    we_i[m]  = 1'b0;
    if (we) begin
      mem_m[adr[AW-1:0]] = dat;
      wr_list.push_back(int'(adr[AW-1:0]));
    end
    last_m = m;
    @(negedge clk);
    n_checks++;
    if (ack_o !== '0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_ack: got ack=%b busy=%b, want ack=0000 busy=0", tag, ack_o, busy_o);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ack_o !== '0 || dat_o !== '0 || busy_o !== 1'b0 || grant_o !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got ack=%b dat=%h busy=%b grant=%0d, want all zero", ack_o, dat_o, busy_o, grant_o);
    end
    rst = 1'b0;
    last_m = N - 1;
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || ack_o !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b ack=%b, want 0/0000", busy_o, ack_o);
    end
  endtask

  task automatic test_single;
    logic [31:0] a;
    single(0, 1'b1, 32'd5, 32'hDEADBEEF, "m0_store");
    single(0, 1'b0, 32'd5, 32'h0, "m0_load");
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 2) begin
        a = 32'(wr_list[$urandom_range(0, wr_list.size() - 1)]) | ($urandom << AW);
        single(int'($urandom_range(0, N - 1)), 1'b0, a, $urandom, "rand_load");
      end else begin
        single(int'($urandom_range(0, N - 1)), 1'b1, $urandom, $urandom, "rand_store");
      end
    end
  endtask

  task automatic test_wrap;
    single(2, 1'b1, 32'h400, 32'h12345678, "wrap_store");
    single(1, 1'b0, 32'h0, 32'h0, "wrap_load");
  endtask

  task automatic test_abort;
    @(negedge clk);
    cyc_i[3] = 1'b1;
    we_i[3]  = 1'b1;
    adr_i[3*32 +: 32] = 32'd7;
    dat_i[3*32 +: 32] = 32'hA5A5A5A5;
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b1 || grant_o !== 2'd3) begin
      n_fail++;
      $display("FAIL abort_access: got busy=%b grant=%0d, want 1/3", busy_o, grant_o);
    end
    cyc_i[3] = 1'b0;
    we_i[3]  = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ack_o !== '0) begin n_fail++; $display("FAIL abort_no_ack: got %b, want 0000", ack_o); end
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%b, want 0", busy_o); end
    mem_m[7] = 32'hA5A5A5A5;
    wr_list.push_back(7);
    last_m = 3;
    single(0, 1'b0, 32'd7, 32'h0, "abort_readback");
  endtask

  task automatic test_back_to_back;
    int k;
    int cycles;
    int prev;
    for (int a = 1; a <= 3; a++) single(0, 1'b1, 32'(a), $urandom, "b2b_prep");
    @(negedge clk);
    cyc_i[1] = 1'b1;
    we_i[1]  = 1'b0;
    adr_i[1*32 +: 32] = 32'd1;
    k = 0;
    cycles = 0;
    prev = 0;
    while (k < 3 && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (ack_o !== '0) begin
        n_checks++;
        if (ack_o !== 4'b0010) begin n_fail++; $display("FAIL b2b_ack_vec: got %b, want 0010", ack_o); end
        n_checks++;
        if (dat_o !== mem_m[k + 1]) begin n_fail++; $display("FAIL b2b_data%0d: got %h, want %h", k, dat_o, mem_m[k + 1]); end
        n_checks++;
        if ((k == 0 && cycles != 2) || (k != 0 && cycles - prev != 3)) begin
          n_fail++;
          $display("FAIL b2b_spacing%0d: got cycle %0d (prev %0d), want 2 then +3", k, cycles, prev);
        end
        prev = cycles;
        k++;
        if (k < 3) adr_i[1*32 +: 32] = 32'(k + 1);
        else       cyc_i[1] = 1'b0;
      end
    end
    n_checks++;
    if (k !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d acks, want 3", k); end
    cyc_i[1] = 1'b0;
    last_m = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (ack_o !== '0) begin n_fail++; $display("FAIL b2b_extra_ack: got %b, want 0000", ack_o); end
    end
  endtask

  task automatic contend(input logic [3:0] mask, input string tag);
    logic [3:0]  pend;
    logic [3:0]  exp_ack;
    logic [31:0] addr [N];
    int          cycles;
    int          prev;
    int          exp_m;
    bit          first;
    pend = mask;
    @(negedge clk);
    for (int m = 0; m < N; m++) begin
      addr[m] = 32'(wr_list[$urandom_range(0, wr_list.size() - 1)]) | ($urandom << AW);
      adr_i[m*32 +: 32] = addr[m];
      dat_i[m*32 +: 32] = $urandom;
    end
    we_i  = '0;
    cyc_i = mask;
    cycles = 0;
    prev = 0;
    first = 1'b1;
    while (pend != 0 && cycles < 100) begin
      @(negedge clk);
      cycles++;
      n_checks++;
      if ($countones(ack_o) > 1) begin n_fail++; $display("FAIL %s onehot: got %b", tag, ack_o); end
      if (ack_o != '0) begin
        exp_m = 0;
        for (int s = N; s >= 1; s--)
          if (pend[(last_m + s) % N]) exp_m = (last_m + s) % N;
        exp_ack = 4'(1 << exp_m);
        n_checks++;
        if (ack_o !== exp_ack) begin n_fail++; $display("FAIL %s order: got %b, want %b", tag, ack_o, exp_ack); end
        n_checks++;
        if (dat_o !== mem_m[addr[exp_m][AW-1:0]]) begin
          n_fail++;
          $display("FAIL %s data_m%0d: got %h, want %h", tag, exp_m, dat_o, mem_m[addr[exp_m][AW-1:0]]);
        end
        n_checks++;
        if ((first && cycles != 2) || (!first && cycles - prev != 3)) begin
          n_fail++;
          $display("FAIL %s spacing: got cycle %0d (prev %0d), want 2 then +3", tag, cycles, prev);
        end
        first = 1'b0;
        prev = cycles;
        pend[exp_m] = 1'b0;
        cyc_i[exp_m] = 1'b0;
        last_m = exp_m;
      end
    end
    n_checks++;
    if (pend !== 4'b0000) begin n_fail++; $display("FAIL %s timeout: pending %b, want 0000", tag, pend); end
    cyc_i = '0;
    @(negedge clk);
  endtask

  task automatic test_contention;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_m = N - 1;
    contend(4'b1111, "contend_all");
    for (int r = 0; r < 6; r++) contend(4'($urandom_range(1, 15)), "contend_rand");
  endtask

  task automatic test_reset_mid;
    bit seen;
    int n;
    @(negedge clk);
    cyc_i[2] = 1'b1;
    we_i[2]  = 1'b0;
    adr_i[2*32 +: 32] = 32'd5;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      seen = ack_o[2];
    end
    n_checks++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_ack: got no ack in %0d cycles", n); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (ack_o !== '0 || dat_o !== '0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: got ack=%b dat=%h busy=%b, want zeros", ack_o, dat_o, busy_o);
    end
    cyc_i = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_m = N - 1;
    single(3, 1'b0, 32'd5, 32'h0, "rstmid_ram_kept");
  endtask

  initial begin
    rst   = 1'b1;
    cyc_i = '0;
    we_i  = '0;
    adr_i = '0;
    dat_i = '0;
    last_m = N - 1;
    test_reset();
    test_single();
    test_wrap();
    test_abort();
    test_back_to_back();
    test_contention();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
